// File: rtl/sipo_frame_reg.sv
// sipo_frame_reg: serial-in/parallel-out frame assembler with a valid/ready
// output stage and sticky overrun detection.
//
// Optional feature macro: SIPO_PARITY_EN
//   defined   -> each frame carries a trailing even-parity bit (FL = WIDTH+1);
//                parity_err is registered alongside out_data.
//   undefined -> FL = WIDTH, parity_err tied low.
//
// Parameters:
//   WIDTH      frame/data width in bits (>= 2)
//   LSB_FIRST  0: first received bit ends in out_data[WIDTH-1]; 1: in out_data[0]
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous clear, highest priority
//   shift_en     accept bit_in this cycle
//   bit_in       serial data bit
//   shift_data   live shift register contents
//   bit_count    bits received of the current frame (0 = frame boundary)
//   out_data     completed frame, stable while out_valid
//   out_valid    completed frame available
//   out_ready    consumer accepts out_data when out_valid && out_ready
//   overrun      sticky: a completed frame was dropped
//   parity_err   parity check result for out_data
module sipo_frame_reg #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            shift_en,
  input  logic                            bit_in,
  output logic [WIDTH-1:0]                shift_data,
  output logic [$clog2(WIDTH+2)-1:0]      bit_count,
  output logic [WIDTH-1:0]                out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            overrun,
  output logic                            parity_err
);

  localparam int CW = $clog2(WIDTH+2);
`ifdef SIPO_PARITY_EN
  localparam int unsigned FL = WIDTH + 1;
`else
  localparam int unsigned FL = WIDTH;
`endif
  localparam logic [CW-1:0] LAST = CW'(FL - 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             shift_bit;
  logic             load;
  logic             drop;

  always_comb begin
    shift_nxt = shift_data;
    if (LSB_FIRST) shift_nxt = {bit_in, shift_data[WIDTH-1:1]};
    else           shift_nxt = {shift_data[WIDTH-2:0], bit_in};
  end

  assign complete = shift_en && (bit_count == LAST);

`ifdef SIPO_PARITY_EN
  // The final bit is parity: it is not shifted in, so the word is the
  // shift register as it stands on the completing edge.
  assign shift_bit = shift_en && (bit_count != LAST);
  assign word      = shift_data;
`else
  assign shift_bit = shift_en;
  assign word      = shift_nxt;
`endif

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      EMPTY: begin
        if (complete) begin
          state_nxt = FULL;
          load      = 1'b1;
        end
      end
      FULL: begin
        if (complete) begin
          // A completion while full either replaces the accepted word or is lost.
          if (out_ready) load = 1'b1;
          else           drop = 1'b1;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign out_valid = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      shift_data <= '0;
      bit_count  <= '0;
      out_data   <= '0;
      overrun    <= 1'b0;
    end else if (clear) begin
      state      <= EMPTY;
      shift_data <= '0;
      bit_count  <= '0;
      out_data   <= '0;
      overrun    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (shift_en)  bit_count  <= complete ? '0 : bit_count + CW'(1);
      if (shift_bit) shift_data <= shift_nxt;
      if (load)      out_data   <= word;
      if (drop)      overrun    <= 1'b1;
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      parity_err <= 1'b0;
    else if (clear)  parity_err <= 1'b0;
    else if (load)   parity_err <= (^shift_data) ^ bit_in;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_reg.sv
// Testbench for sipo_frame_reg: one MSB-first and one LSB-first instance
// (WIDTH=8) sharing control inputs, with separate serial data inputs.
// Honours SIPO_PARITY_EN by appending a parity bit to every frame.
module tb_sipo_frame_reg;

  localparam int W  = 8;
  localparam int CW = $clog2(W+2);
`ifdef SIPO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;
  logic shift_en = 1'b0;
  logic bit_in = 1'b0;
  logic bit_in_l = 1'b0;
  logic out_ready = 1'b0;

  logic [W-1:0]  sd, od, sd_l, od_l;
  logic [CW-1:0] bc, bc_l;
  logic          ov, orun, perr, ov_l, orun_l, perr_l;

  int checks = 0;
  int errors = 0;

  sipo_frame_reg #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .clear(clear), .shift_en(shift_en), .bit_in(bit_in),
    .shift_data(sd), .bit_count(bc), .out_data(od), .out_valid(ov),
    .out_ready(out_ready), .overrun(orun), .parity_err(perr)
  );

  sipo_frame_reg #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .clear(clear), .shift_en(shift_en), .bit_in(bit_in_l),
    .shift_data(sd_l), .bit_count(bc_l), .out_data(od_l), .out_valid(ov_l),
    .out_ready(out_ready), .overrun(orun_l), .parity_err(perr_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         bit_v;
    logic [W-1:0] e_sd;
    logic [3:0]   e_bc;
    logic         e_ov;
    logic [W-1:0] e_od;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_sd, input logic [3:0] e_bc,
                           input logic e_ov, input logic [7:0] e_od, input logic e_or,
                           input logic e_pe);
    chk({tag, ".shift_data"}, 32'(sd),   32'(e_sd));
    chk({tag, ".bit_count"},  32'(bc),   32'(e_bc));
    chk({tag, ".out_valid"},  32'(ov),   32'(e_ov));
    chk({tag, ".out_data"},   32'(od),   32'(e_od));
    chk({tag, ".overrun"},    32'(orun), 32'(e_or));
    chk({tag, ".parity_err"}, 32'(perr), 32'(e_pe));
  endtask

  task automatic step(input logic c, input logic se, input logic b, input logic bl,
                      input logic rdy);
    clear = c; shift_en = se; bit_in = b; bit_in_l = bl; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Send one byte MSB-first to the MSB instance; ready is raised only on the
  // completing edge. pbit is the parity bit appended in parity builds.
  task automatic send_msb(input logic [7:0] v, input logic pbit, input logic rdy_last);
    for (int i = 7; i >= 0; i--)
      step(1'b0, 1'b1, v[i], 1'b0, (!PAR && i == 0) ? rdy_last : 1'b0);
    if (PAR) step(1'b0, 1'b1, pbit, 1'b0, rdy_last);
  endtask

  logic [7:0] model;
  logic [7:0] v;

  initial begin
    // Table for test 1: 8'hCB MSB-first (1,1,0,0,1,0,1,1).
    tbl[0] = '{1'b1, 8'h01, 4'd1, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'h03, 4'd2, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 8'h06, 4'd3, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 8'h0C, 4'd4, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 8'h19, 4'd5, 1'b0, 8'h00};
    tbl[5] = '{1'b0, 8'h32, 4'd6, 1'b0, 8'h00};
    tbl[6] = '{1'b1, 8'h65, 4'd7, 1'b0, 8'h00};
    tbl[7] = PAR ? '{1'b1, 8'hCB, 4'd8, 1'b0, 8'h00} : '{1'b1, 8'hCB, 4'd0, 1'b1, 8'hCB};
    tbl[8] = '{1'b1, 8'hCB, 4'd0, 1'b1, 8'hCB}; // parity bit: CB has five ones

    // Reset
    #1 rst_n = 1'b0;
    #2;
    check_all("reset", 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("idle", 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Test 1: table-driven MSB-first frame
    for (int i = 0; i < (PAR ? 9 : 8); i++) begin
      step(1'b0, 1'b1, tbl[i].bit_v, 1'b0, 1'b0);
      chk($sformatf("t1[%0d].shift_data", i), 32'(sd), 32'(tbl[i].e_sd));
      chk($sformatf("t1[%0d].bit_count", i),  32'(bc), 32'(tbl[i].e_bc));
      chk($sformatf("t1[%0d].out_valid", i),  32'(ov), 32'(tbl[i].e_ov));
      chk($sformatf("t1[%0d].out_data", i),   32'(od), 32'(tbl[i].e_od));
    end
    chk("t1.overrun", 32'(orun), 32'd0);

    // Test 2: LSB-first instance, 8'hCB sent bit 0 first
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    v = 8'hCB;
    model = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, v[i], 1'b0);
      model = {v[i], model[7:1]};
      chk($sformatf("t2[%0d].shift_data", i), 32'(sd_l), 32'(model));
    end
    if (PAR) step(1'b0, 1'b1, 1'b0, ^v, 1'b0);
    chk("t2.out_data",  32'(od_l), 32'h0000_00CB);
    chk("t2.out_valid", 32'(ov_l), 32'd1);
    chk("t2.bit_count", 32'(bc_l), 32'd0);

    // Test 3: stalled consumer, second frame dropped, then clear
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("t3.clear0", 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_msb(8'hA5, ^(8'hA5), 1'b0);
    check_all("t3.first", 8'hA5, 4'd0, 1'b1, 8'hA5, 1'b0, 1'b0);
    send_msb(8'h3C, ^(8'h3C), 1'b0);
    check_all("t3.drop", 8'h3C, 4'd0, 1'b1, 8'hA5, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3.overrun_sticky", 32'(orun), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check_all("t3.clear", 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Test 4: ready on the completing edge of the second frame
    send_msb(8'hA5, ^(8'hA5), 1'b0);
    send_msb(8'h3C, ^(8'h3C), 1'b1);
    check_all("t4.replace", 8'h3C, 4'd0, 1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_all("t4.accept", 8'h3C, 4'd0, 1'b0, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4.empty_hold", 32'(ov), 32'd0);

    // Test 5: async reset after 3 bits discards the partial frame
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5.partial_count", 32'(bc), 32'd3);
    chk("t5.partial_data",  32'(sd), 32'h0000_00E5);
    shift_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all("t5.async", 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5.first_bit_count", 32'(bc), 32'd1);
    for (int i = 6; i >= 0; i--) step(1'b0, 1'b1, (i == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
    if (PAR) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("t5.frame", 8'h81, 4'd0, 1'b1, 8'h81, 1'b0, 1'b0);

`ifdef SIPO_PARITY_EN
    // Test 6: parity check
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_msb(8'hCB, 1'b1, 1'b0);
    check_all("t6.good", 8'hCB, 4'd0, 1'b1, 8'hCB, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_msb(8'hCB, 1'b0, 1'b0);
    check_all("t6.bad", 8'hCB, 4'd0, 1'b1, 8'hCB, 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
